// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - sequencing controller for a 4-way set-associative cache array
//
// Purpose:
//   Takes one CPU load/store at a time and drives the cache array's lookup.
//   - Hit: updates the LRU state and, for a store, the dirty bit.
//   - Miss: writes back a dirty victim beat by beat, refills the line from
//     next-level memory, installs the tag, then replays the lookup.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_cpu_req/we/addr         CPU request (accepted when req & o_cpu_ready)
//   o_cpu_ready, o_cpu_done   idle indication, 1-cycle completion pulse
//   o_tag, o_index            latched request address fields driven to the array
//   i_hit                     per-way hit vector from the array (combinational)
//   i_victim_way/dirty/tag    LRU victim information for o_index
//   o_mem_req/we/addr         memory beat request, held until i_mem_ack
//   i_mem_ack                 beat accepted/returned this cycle
//   o_beat                    current beat number (array word select)
//   o_fill_en, o_fill_way     write refill beat into the array
//   o_tag_wr                  install tag, set valid, clear dirty in o_fill_way
//   o_set_dirty               set dirty bit of the hit way (store hit)
//   o_lru_update, o_lru_way   mark the way most-recently-used
//   o_err_multihit            sticky: more than one way hit during a lookup
module cache_ctrl_fsm #(
  parameter  int TAG_BITS    = 18,
  parameter  int INDEX_BITS  = 8,
  parameter  int OFFSET_BITS = 6,
  parameter  int WAYS        = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int WAY_BITS    = $clog2(WAYS),
  localparam int BEATS       = (2**OFFSET_BITS) * 8 / DATA_WIDTH,
  localparam int BEAT_BITS   = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [31:0]           i_cpu_addr,
  output logic                  o_cpu_ready,
  output logic                  o_cpu_done,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [INDEX_BITS-1:0] o_index,
  input  logic [WAYS-1:0]       i_hit,
  input  logic [WAY_BITS-1:0]   i_victim_way,
  input  logic                  i_victim_dirty,
  input  logic [TAG_BITS-1:0]   i_victim_tag,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_addr,
  input  logic                  i_mem_ack,
  output logic [BEAT_BITS-1:0]  o_beat,
  output logic                  o_fill_en,
  output logic [WAY_BITS-1:0]   o_fill_way,
  output logic                  o_tag_wr,
  output logic                  o_set_dirty,
  output logic                  o_lru_update,
  output logic [WAY_BITS-1:0]   o_lru_way,
  output logic                  o_err_multihit
);

  localparam int BYTE_BITS = OFFSET_BITS - BEAT_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_REFILL,
    S_INSTALL
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic                  we_q, we_d;
  logic [TAG_BITS-1:0]   vtag_q, vtag_d;
  logic [WAY_BITS-1:0]   vway_q, vway_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  lru_upd_q, lru_upd_d;
  logic [WAY_BITS-1:0]   lru_way_q, lru_way_d;
  logic                  set_dirty_q, set_dirty_d;
  logic                  tag_wr_q, tag_wr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  err_q, err_d;

  logic [WAY_BITS-1:0]   hit_way;
  logic                  multi_hit;
  logic [TAG_BITS-1:0]   beat_tag;

  // Byte offset never affects sequencing: whole lines are moved.
  logic unused_offset;
  assign unused_offset = ^i_cpu_addr[OFFSET_BITS-1:0];

  // Lowest-numbered hitting way wins; clearing the lowest set bit
  // leaves something behind only when two or more ways hit.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_hit[w]) hit_way = w[WAY_BITS-1:0];
    end
    multi_hit = |(i_hit & (i_hit - {{(WAYS-1){1'b0}}, 1'b1}));
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    index_d     = index_q;
    we_d        = we_q;
    vtag_d      = vtag_q;
    vway_d      = vway_q;
    beat_d      = beat_q;
    lru_way_d   = lru_way_q;
    err_d       = err_q;
    done_d      = 1'b0;
    lru_upd_d   = 1'b0;
    set_dirty_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cpu_req) begin
          tag_d   = i_cpu_addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
          index_d = i_cpu_addr[OFFSET_BITS +: INDEX_BITS];
          we_d    = i_cpu_we;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|i_hit) begin
          done_d      = 1'b1;
          lru_upd_d   = 1'b1;
          lru_way_d   = hit_way;
          set_dirty_d = we_q;
          if (multi_hit) err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          vway_d  = i_victim_way;
          vtag_d  = i_victim_tag;
          beat_d  = '0;
          state_d = i_victim_dirty ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        if (i_mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_REFILL;
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end
      S_REFILL: begin
        if (i_mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_INSTALL;
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end
      S_INSTALL: begin
        state_d = S_LOOKUP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    ready_d    = (state_d == S_IDLE);
    tag_wr_d   = (state_d == S_INSTALL);
    mem_req_d  = (state_d == S_WB) || (state_d == S_REFILL);
    mem_we_d   = (state_d == S_WB);
    beat_tag   = (state_d == S_WB) ? vtag_d : tag_d;
    mem_addr_d = {beat_tag, index_d, beat_d, {BYTE_BITS{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      we_q        <= 1'b0;
      vtag_q      <= '0;
      vway_q      <= '0;
      beat_q      <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      lru_upd_q   <= 1'b0;
      lru_way_q   <= '0;
      set_dirty_q <= 1'b0;
      tag_wr_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      we_q        <= we_d;
      vtag_q      <= vtag_d;
      vway_q      <= vway_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      lru_upd_q   <= lru_upd_d;
      lru_way_q   <= lru_way_d;
      set_dirty_q <= set_dirty_d;
      tag_wr_q    <= tag_wr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
    end
  end

  assign o_cpu_ready    = ready_q;
  assign o_cpu_done     = done_q;
  assign o_tag          = tag_q;
  assign o_index        = index_q;
  assign o_mem_req      = mem_req_q;
  assign o_mem_we       = mem_we_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_beat         = beat_q;
  assign o_fill_way     = vway_q;
  assign o_tag_wr       = tag_wr_q;
  assign o_set_dirty    = set_dirty_q;
  assign o_lru_update   = lru_upd_q;
  assign o_lru_way      = lru_way_q;
  assign o_err_multihit = err_q;

  // The refill write must coincide with the ack that returns the beat,
  // so it is the one output left combinational.
  assign o_fill_en = (state_q == S_REFILL) && i_mem_ack;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - scoreboard testbench for cache_ctrl_fsm
module tb_cache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cpu_req = 1'b0;
  logic        i_cpu_we = 1'b0;
  logic [31:0] i_cpu_addr = '0;
  logic        o_cpu_ready, o_cpu_done;
  logic [17:0] o_tag;
  logic [7:0]  o_index;
  logic [3:0]  i_hit = '0;
  logic [1:0]  i_victim_way = '0;
  logic        i_victim_dirty = 1'b0;
  logic [17:0] i_victim_tag = '0;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [3:0]  o_beat;
  logic        o_fill_en;
  logic [1:0]  o_fill_way;
  logic        o_tag_wr, o_set_dirty, o_lru_update;
  logic [1:0]  o_lru_way;
  logic        o_err_multihit;

  cache_ctrl_fsm dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .o_cpu_ready(o_cpu_ready), .o_cpu_done(o_cpu_done),
    .o_tag(o_tag), .o_index(o_index),
    .i_hit(i_hit), .i_victim_way(i_victim_way), .i_victim_dirty(i_victim_dirty),
    .i_victim_tag(i_victim_tag),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .o_beat(o_beat),
    .o_fill_en(o_fill_en), .o_fill_way(o_fill_way), .o_tag_wr(o_tag_wr),
    .o_set_dirty(o_set_dirty), .o_lru_update(o_lru_update), .o_lru_way(o_lru_way),
    .o_err_multihit(o_err_multihit)
  );

  always #5 clk = ~clk;

  localparam int K_BEAT  = 0;
  localparam int K_TAGWR = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  beat;
    logic [1:0]  way;
    logic [17:0] tag;
    logic [7:0]  idx;
    logic        sd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic started = 1'b0;
  logic junk_en = 1'b0;
  logic sticky = 1'b0;
  logic stall_mode = 1'b0;
  int   stall_cnt = 0;
  logic [31:0] stall_exp_addr = '0;
  logic rst_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at cycle %0d", name, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [31:0] beat_addr(input logic [17:0] tag, input logic [7:0] idx,
                                            input int b);
    return (32'(tag) << 14) | (32'(idx) << 6) | (32'(b) << 2);
  endfunction

  // Monitor: every observable DUT event is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started && !rst) begin
        chk("fill_en_only_on_refill_ack", 32'(o_fill_en),
            32'(o_mem_req && i_mem_ack && !o_mem_we));
        if (o_mem_req && o_cpu_ready) chk("ready_low_while_busy", 32'(o_cpu_ready), 32'd0);
        if (o_mem_req && i_mem_ack) begin
          if (sbq.size() == 0 || sbq[0].kind != K_BEAT) begin
            chk("unexpected_mem_beat", o_mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("beat_addr", o_mem_addr, e.addr);
            chk("beat_we", 32'(o_mem_we), 32'(e.we));
            chk("beat_num", 32'(o_beat), 32'(e.beat));
            if (!e.we) chk("fill_way", 32'(o_fill_way), 32'(e.way));
          end
        end
        if (o_tag_wr) begin
          if (sbq.size() == 0 || sbq[0].kind != K_TAGWR) begin
            chk("unexpected_tag_wr", 32'(o_tag_wr), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("tag_wr_way", 32'(o_fill_way), 32'(e.way));
            chk("tag_wr_tag", 32'(o_tag), 32'(e.tag));
            chk("tag_wr_index", 32'(o_index), 32'(e.idx));
          end
        end
        if (o_cpu_done) begin
          if (sbq.size() == 0 || sbq[0].kind != K_DONE) begin
            chk("unexpected_done", 32'(o_cpu_done), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("done_lru_update", 32'(o_lru_update), 32'd1);
            chk("done_lru_way", 32'(o_lru_way), 32'(e.way));
            chk("done_set_dirty", 32'(o_set_dirty), 32'(e.sd));
            chk("done_err_multihit", 32'(o_err_multihit), 32'(e.err));
            if (e.cyc >= 0) chk("hit_latency", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  // Memory responder: random acks, plus a directed stall and a parked beat for the reset test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode && o_mem_req && !o_mem_we && o_beat == 4'd5 && stall_cnt < 10) begin
        i_mem_ack = 1'b0;
        stall_cnt++;
        chk("stall_mem_req", 32'(o_mem_req), 32'd1);
        chk("stall_mem_addr", o_mem_addr, stall_exp_addr);
        chk("stall_beat", 32'(o_beat), 32'd5);
      end else if (rst_mode && o_mem_req && !o_mem_we && o_beat == 4'd7) begin
        i_mem_ack = 1'b0;
      end else begin
        i_mem_ack = o_mem_req && ($urandom_range(0, 3) != 0);
      end
    end
  end

  // One busy cycle; while the DUT is not ready, occasionally throw a request at it
  // that must be ignored.
  task automatic step_busy();
    @(posedge clk);
    #1;
    if (junk_en && !o_cpu_ready && $urandom_range(0, 4) == 0) begin
      i_cpu_req  = 1'b1;
      i_cpu_addr = $urandom;
    end else begin
      i_cpu_req = 1'b0;
    end
    @(negedge clk);
  endtask

  // mode: 0 normal, 1 ack stall at refill beat 5, 2 reset at refill beat 7
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] hit,
                         input logic [1:0] vway, input logic vdirty, input logic [17:0] vtag,
                         input int mode);
    exp_t        e;
    int          n;
    int          t;
    int          nref;
    logic [17:0] tag;
    logic [7:0]  idx;
    tag = addr[31:14];
    idx = addr[13:6];
    t = 0;
    @(negedge clk);
    while (!o_cpu_ready) begin
      step_busy();
      t++;
      if (t > 50) timeout("ready_wait");
    end
    if (mode == 1) begin
      stall_cnt      = 0;
      stall_exp_addr = beat_addr(tag, idx, 5);
      stall_mode     = 1'b1;
    end
    if (mode == 2) rst_mode = 1'b1;
    @(posedge clk);
    #1;
    i_cpu_req      = 1'b1;
    i_cpu_addr     = addr;
    i_cpu_we       = we;
    i_hit          = hit;
    i_victim_way   = vway;
    i_victim_dirty = vdirty;
    i_victim_tag   = vtag;
    n = cyc;
    e = '{kind: K_DONE, addr: '0, we: 1'b0, beat: '0, way: '0, tag: tag, idx: idx,
          sd: we, err: 1'b0, cyc: -1};
    if (hit != 4'd0) begin
      if ($countones(hit) > 1) sticky = 1'b1;
      for (int w = 3; w >= 0; w--) if (hit[w]) e.way = 2'(w);
      e.err = sticky;
      e.cyc = n + 2;
      sbq.push_back(e);
    end else begin
      if (vdirty) begin
        for (int b = 0; b < 16; b++)
          sbq.push_back('{kind: K_BEAT, addr: beat_addr(vtag, idx, b), we: 1'b1, beat: 4'(b),
                          way: vway, tag: tag, idx: idx, sd: 1'b0, err: 1'b0, cyc: -1});
      end
      nref = (mode == 2) ? 7 : 16;
      for (int b = 0; b < nref; b++)
        sbq.push_back('{kind: K_BEAT, addr: beat_addr(tag, idx, b), we: 1'b0, beat: 4'(b),
                        way: vway, tag: tag, idx: idx, sd: 1'b0, err: 1'b0, cyc: -1});
      if (mode != 2) begin
        sbq.push_back('{kind: K_TAGWR, addr: '0, we: 1'b0, beat: '0, way: vway, tag: tag,
                        idx: idx, sd: 1'b0, err: 1'b0, cyc: -1});
        e.way = vway;
        e.err = sticky;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    i_cpu_req = 1'b0;
    @(negedge clk);
    t = 0;
    if (hit != 4'd0) begin
      while (!o_cpu_done) begin
        step_busy();
        t++;
        if (t > 10) timeout("hit_done_wait");
      end
    end else if (mode == 2) begin
      while (!(o_mem_req && !o_mem_we && o_beat == 4'd7)) begin
        step_busy();
        t++;
        if (t > 600) timeout("refill_beat7_wait");
      end
      @(posedge clk);
      #1;
      i_cpu_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rst_mode = 1'b0;
      sticky   = 1'b0;
      @(negedge clk);
      chk("rst_mid_refill_mem_req", 32'(o_mem_req), 32'd0);
      chk("rst_mid_refill_ready", 32'(o_cpu_ready), 32'd1);
      chk("rst_mid_refill_beat", 32'(o_beat), 32'd0);
      chk("rst_clears_multihit", 32'(o_err_multihit), 32'd0);
      chk("rst_scoreboard_drained", 32'(sbq.size()), 32'd0);
      for (int i = 0; i < 5; i++) begin
        chk("rst_no_tag_wr", 32'(o_tag_wr), 32'd0);
        @(negedge clk);
      end
    end else begin
      while (!o_tag_wr) begin
        step_busy();
        t++;
        if (t > 600) timeout("tag_wr_wait");
      end
      i_hit = 4'(1) << vway;
      t = 0;
      while (!o_cpu_done) begin
        step_busy();
        t++;
        if (t > 10) timeout("replay_done_wait");
      end
    end
    if (mode == 1) begin
      chk("stall_cycles_seen", 32'(stall_cnt), 32'd10);
      stall_mode = 1'b0;
    end
    i_hit = 4'd0;
  endtask

  initial begin
    logic [3:0] h;
    int         kind;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(o_cpu_ready), 32'd1);
    chk("reset_mem_req", 32'(o_mem_req), 32'd0);
    chk("reset_done", 32'(o_cpu_done), 32'd0);
    chk("reset_multihit", 32'(o_err_multihit), 32'd0);
    chk("reset_beat", 32'(o_beat), 32'd0);
    chk("reset_tag_wr", 32'(o_tag_wr), 32'd0);

    run_txn(32'h0001_2340, 1'b0, 4'b0100, 2'd0, 1'b0, 18'h0, 0);
    run_txn(32'h0001_2300, 1'b0, 4'b0000, 2'd1, 1'b0, 18'h0, 0);
    run_txn(32'h0001_2300, 1'b1, 4'b0000, 2'd3, 1'b1, 18'h3, 0);
    run_txn(32'h0ABC_D5C0, 1'b0, 4'b0000, 2'd2, 1'b0, 18'h0, 1);
    run_txn(32'h0000_1000, 1'b1, 4'b0110, 2'd0, 1'b0, 18'h0, 0);

    junk_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      h    = (kind == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      run_txn($urandom, 1'($urandom), h, 2'($urandom), kind == 2, 18'($urandom), 0);
    end
    junk_en = 1'b0;

    run_txn(32'h0040_0080, 1'b0, 4'b0000, 2'd1, 1'b0, 18'h0, 2);
    run_txn(32'h0001_2340, 1'b0, 4'b0011, 2'd0, 1'b0, 18'h0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty_at_end", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
